// File: rtl/lifo_stack_pkg.sv
// Shared definitions for the LIFO operand stack.
//   STACK_WIDTH / STACK_DEPTH : default word width and entry count
//   stack_op_t                : operation decoded from clear/push/pop each cycle
package stack_pkg;

  localparam int STACK_WIDTH = 10;
  localparam int STACK_DEPTH = 7;

  typedef enum logic [1:0] {
    OP_NONE,
    OP_PUSH,
    OP_POP,
    OP_REPLACE
  } stack_op_t;

endpackage

// File: rtl/lifo_stack.sv
// Parametrised LIFO operand stack between the tokenizer/control FSM and the ALU.
// Ports:
//   clk, rst_n            clock, async active-low reset
//   clear                 synchronous flush (count -> 0, sticky err cleared)
//   push, push_data       write a word onto the top
//   pop                   remove the top word
//   pop_data, pop_valid   registered popped word and its 1-cycle strobe
//   top_data              combinational peek of the top (0 when empty)
//   count, empty, full    occupancy status
//   ovf, unf              1-cycle pulses for rejected push / pop
//   err                   sticky OR of ovf/unf until clear or reset
module lifo_stack
  import stack_pkg::*;
#(
  parameter  int WIDTH = STACK_WIDTH,
  parameter  int DEPTH = STACK_DEPTH,
  localparam int CNT_W = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clear,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic [WIDTH-1:0] pop_data,
  output logic             pop_valid,
  output logic [WIDTH-1:0] top_data,
  output logic [CNT_W-1:0] count,
  output logic             empty,
  output logic             full,
  output logic             ovf,
  output logic             unf,
  output logic             err
);

  // Address width for the storage array; count needs one extra code for "full".
  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [WIDTH-1:0] mem [0:DEPTH-1];

  stack_op_t        op;
  logic             ovf_req;
  logic             unf_req;
  logic [CNT_W-1:0] cnt_m1;
  logic [AW-1:0]    wr_idx;
  logic [AW-1:0]    top_idx;

  assign empty = (count == '0);
  assign full  = (count == CNT_W'(DEPTH));

  always_comb begin
    cnt_m1  = count - CNT_W'(1);
    // Both indices are only used when in range: wr_idx when !full,
    // top_idx when !empty.
    wr_idx  = count[AW-1:0];
    top_idx = cnt_m1[AW-1:0];
  end

  assign top_data = empty ? '0 : mem[top_idx];

  // Op decode: clear masks push/pop entirely, including the error requests.
  always_comb begin
    op      = OP_NONE;
    ovf_req = 1'b0;
    unf_req = 1'b0;
    if (!clear) begin
      unique case ({push, pop})
        2'b10: begin
          if (full) ovf_req = 1'b1;
          else      op      = OP_PUSH;
        end
        2'b01: begin
          if (empty) unf_req = 1'b1;
          else       op      = OP_POP;
        end
        // Push+pop never over/underflows: replace-top, or bypass when empty.
        2'b11:   op = OP_REPLACE;
        default: op = OP_NONE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count     <= '0;
      pop_data  <= '0;
      pop_valid <= 1'b0;
      ovf       <= 1'b0;
      unf       <= 1'b0;
      err       <= 1'b0;
    end else begin
      pop_valid <= 1'b0;
      ovf       <= ovf_req;
      unf       <= unf_req;
      if (clear) begin
        count <= '0;
        err   <= 1'b0;
      end else begin
        if (ovf_req || unf_req) err <= 1'b1;
        unique case (op)
          OP_PUSH: count <= count + CNT_W'(1);
          OP_POP: begin
            pop_data  <= mem[top_idx];
            pop_valid <= 1'b1;
            count     <= cnt_m1;
          end
          OP_REPLACE: begin
            // Empty stack: the pushed word passes straight through.
            pop_data  <= empty ? push_data : mem[top_idx];
            pop_valid <= 1'b1;
          end
          default: ;
        endcase
      end
    end
  end

  // Storage is never reset; top_data gating hides stale contents.
  always_ff @(posedge clk) begin
    if (op == OP_PUSH)
      mem[wr_idx] <= push_data;
    else if (op == OP_REPLACE && !empty)
      mem[top_idx] <= push_data;
  end

endmodule

// File: tb/tb_lifo_stack.sv
module tb_lifo_stack;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        clear = 1'b0;
  logic        push = 1'b0;
  logic        pop = 1'b0;
  logic [15:0] push_data = '0;
  logic        sel = 1'b0;  // 0: default 10x7 instance, 1: 16x4 instance

  always #5 clk = ~clk;

  // Instance A: WIDTH=10, DEPTH=7
  logic [9:0]  a_pop_data, a_top_data;
  logic [2:0]  a_count;
  logic        a_pop_valid, a_empty, a_full, a_ovf, a_unf, a_err;
  // Instance B: WIDTH=16, DEPTH=4
  logic [15:0] b_pop_data, b_top_data;
  logic [2:0]  b_count;
  logic        b_pop_valid, b_empty, b_full, b_ovf, b_unf, b_err;

  lifo_stack dut_a (
    .clk(clk), .rst_n(rst_n), .clear(clear & ~sel), .push(push & ~sel),
    .push_data(push_data[9:0]), .pop(pop & ~sel),
    .pop_data(a_pop_data), .pop_valid(a_pop_valid), .top_data(a_top_data),
    .count(a_count), .empty(a_empty), .full(a_full),
    .ovf(a_ovf), .unf(a_unf), .err(a_err)
  );

  lifo_stack #(.WIDTH(16), .DEPTH(4)) dut_b (
    .clk(clk), .rst_n(rst_n), .clear(clear & sel), .push(push & sel),
    .push_data(push_data), .pop(pop & sel),
    .pop_data(b_pop_data), .pop_valid(b_pop_valid), .top_data(b_top_data),
    .count(b_count), .empty(b_empty), .full(b_full),
    .ovf(b_ovf), .unf(b_unf), .err(b_err)
  );

  logic [15:0] o_pop_data, o_top_data;
  logic [2:0]  o_count;
  logic        o_pop_valid, o_empty, o_full, o_ovf, o_unf, o_err;

  assign o_pop_data  = sel ? b_pop_data  : {6'b0, a_pop_data};
  assign o_top_data  = sel ? b_top_data  : {6'b0, a_top_data};
  assign o_count     = sel ? b_count     : a_count;
  assign o_pop_valid = sel ? b_pop_valid : a_pop_valid;
  assign o_empty     = sel ? b_empty     : a_empty;
  assign o_full      = sel ? b_full      : a_full;
  assign o_ovf       = sel ? b_ovf       : a_ovf;
  assign o_unf       = sel ? b_unf       : a_unf;
  assign o_err       = sel ? b_err       : a_err;

  int n_cmp = 0;
  int n_bad = 0;
  logic [15:0] exp_q[$];

  task automatic chk(input string nm, input logic [15:0] act, input logic [15:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s (sel=%0d): got 0x%0h expected 0x%0h", nm, sel, act, exp);
    end
  endtask

  // Scoreboard monitor: every pop_valid strobe must match the oldest expected word.
  always @(negedge clk) begin
    if (rst_n && o_pop_valid) begin
      if (exp_q.size() == 0) begin
        chk("unexpected_pop_valid", 16'h1, 16'h0);
      end else begin
        chk("pop_data", o_pop_data, exp_q.pop_front());
      end
    end
  end

  task automatic step(input logic pu, input logic po, input logic cl, input logic [15:0] d);
    push = pu; pop = po; clear = cl; push_data = d;
    @(posedge clk);
    #1;
    push = 1'b0; pop = 1'b0; clear = 1'b0; push_data = '0;
  endtask

  task automatic run_seq(input int depth);
    // 1: reset, fill
    rst_n = 1'b0;
    @(posedge clk); #1;
    chk("rst_count", 16'(o_count), 16'h0);
    chk("rst_pop_valid", 16'(o_pop_valid), 16'h0);
    rst_n = 1'b1;
    step(0, 0, 0, 0);
    chk("rst_empty", 16'(o_empty), 16'h1);
    chk("rst_pop_data", o_pop_data, 16'h0);
    chk("rst_err", 16'(o_err), 16'h0);
    chk("rst_top", o_top_data, 16'h0);
    for (int i = 1; i <= depth; i++) step(1, 0, 0, 16'(i));
    chk("fill_count", 16'(o_count), 16'(depth));
    chk("fill_full", 16'(o_full), 16'h1);
    chk("fill_top", o_top_data, 16'(depth));
    chk("fill_err", 16'(o_err), 16'h0);

    // 2: overflow
    step(1, 0, 0, 16'h3FF);
    chk("ovf_pulse", 16'(o_ovf), 16'h1);
    chk("ovf_err", 16'(o_err), 16'h1);
    chk("ovf_count", 16'(o_count), 16'(depth));
    chk("ovf_top", o_top_data, 16'(depth));
    step(0, 0, 0, 0);
    chk("ovf_one_cycle", 16'(o_ovf), 16'h0);
    chk("ovf_err_sticky", 16'(o_err), 16'h1);

    // 3: drain
    for (int i = depth; i >= 1; i--) begin
      exp_q.push_back(16'(i));
      step(0, 1, 0, 0);
    end
    chk("drain_empty", 16'(o_empty), 16'h1);
    chk("drain_top", o_top_data, 16'h0);
    chk("drain_count", 16'(o_count), 16'h0);
    chk("drain_unf", 16'(o_unf), 16'h0);

    // 4: underflow, then clear
    step(0, 1, 0, 0);
    chk("unf_pulse", 16'(o_unf), 16'h1);
    chk("unf_pop_valid", 16'(o_pop_valid), 16'h0);
    chk("unf_pop_data_hold", o_pop_data, 16'h1);
    step(0, 0, 0, 0);
    chk("unf_one_cycle", 16'(o_unf), 16'h0);
    chk("unf_err_sticky", 16'(o_err), 16'h1);
    step(1, 0, 1, 16'h0FF);  // push ignored under clear
    chk("clear_err", 16'(o_err), 16'h0);
    chk("clear_count", 16'(o_count), 16'h0);

    // 5: replace-top and empty bypass
    step(1, 0, 0, 16'h0AA);
    exp_q.push_back(16'h0AA);
    step(1, 1, 0, 16'h055);
    chk("repl_count", 16'(o_count), 16'h1);
    chk("repl_top", o_top_data, 16'h055);
    chk("repl_ovf", 16'(o_ovf), 16'h0);
    exp_q.push_back(16'h055);
    step(0, 1, 0, 0);
    chk("repl_pop_count", 16'(o_count), 16'h0);
    exp_q.push_back(16'h123);
    step(1, 1, 0, 16'h123);
    chk("bypass_count", 16'(o_count), 16'h0);
    chk("bypass_empty", 16'(o_empty), 16'h1);
    chk("bypass_unf", 16'(o_unf), 16'h0);
    step(0, 0, 0, 0);

    // 6: reset in the middle of a pop
    step(1, 0, 0, 16'h011);
    step(1, 0, 0, 16'h022);
    step(1, 0, 0, 16'h033);
    chk("pre_rst_count", 16'(o_count), 16'h3);
    step(0, 1, 0, 0);  // pop_valid now high; reset lands before the monitor samples
    rst_n = 1'b0;
    #1;
    chk("midrst_count", 16'(o_count), 16'h0);
    chk("midrst_pop_valid", 16'(o_pop_valid), 16'h0);
    chk("midrst_pop_data", o_pop_data, 16'h0);
    #1;
    rst_n = 1'b1;
    step(0, 0, 0, 0);
    step(0, 0, 0, 0);
    chk("sb_drained", 16'(exp_q.size()), 16'h0);
    exp_q.delete();
  endtask

  initial begin
    sel = 1'b0;
    run_seq(7);
    sel = 1'b1;
    run_seq(4);
    // Wide-data check on the 16-bit instance
    exp_q.push_back(16'hBEEF);
    step(1, 1, 0, 16'hBEEF);
    step(0, 0, 0, 0);
    chk("wide_sb_drained", 16'(exp_q.size()), 16'h0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
